vga_mode_ctrl: RTL and testbench

- Run-time video-mode controller for the VGA timing generator.
- Holds the active mode's timing parameters and drives them to the generator.
- Sequences glitch-free mode switches: blank the output, wait for a frame boundary, halt the generator, load the new parameters, restart, hold blank for a settle period.
- Sits between the host/switch logic and the sync/pixel generator in the `pxl_clk` domain.

---
 rtl/vga_mode_ctrl_if.sv | 19 +
 rtl/vga_mode_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_vga_mode_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mode_ctrl_if.sv
// Host-side mode request handshake for vga_mode_ctrl.
// The host drives the mode select and request pulse; the controller answers with ack, busy and drop status.
interface vga_mode_ctrl_if;
  logic [1:0] mode_sel;
  logic       mode_req;
  logic       mode_ack;
  logic       busy;
  logic       req_drop;

  modport master (
    output mode_sel, mode_req,
    input  mode_ack, busy, req_drop
  );

  modport slave (
    input  mode_sel, mode_req,
    output mode_ack, busy, req_drop
  );
endinterface

// File: rtl/vga_mode_ctrl.sv
// Run-time VGA mode controller: sequences glitch-free mode switches.
// Optional frame-wait watchdog: define VGA_MODE_CTRL_WDT_EN.
module vga_mode_ctrl #(
  parameter int RESET_MODE   = 3,
  parameter int HALT_CYCLES  = 16,
  parameter int BLANK_FRAMES = 2,
  parameter int WDT_CYCLES   = 2000000
) (
  input  logic        pxl_clk,
  input  logic        pxl_rstn,
  vga_mode_ctrl_if.slave host,
  input  logic        frame_start,
  output logic        tg_en,
  output logic        blank,
  output logic [1:0]  mode_cur,
  output logic [11:0] frame_width,
  output logic [11:0] frame_height,
  output logic [11:0] h_fp,
  output logic [11:0] h_pw,
  output logic [11:0] h_max,
  output logic [11:0] v_fp,
  output logic [11:0] v_pw,
  output logic [11:0] v_max,
  output logic        h_pol,
  output logic        v_pol
);

  localparam int HW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam int FW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALT_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLANK_FRAMES - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, WAIT_FRAME, HALT, RUN_BLANK
  } state_t;

  typedef struct packed {
    logic [11:0] w, h;
    logic [11:0] hfp, hpw, hmax;
    logic [11:0] vfp, vpw, vmax;
    logic        hpol, vpol;
  } mode_t;

  function automatic mode_t mode_tab(input logic [1:0] m);
    mode_t t;
    unique case (m)
      2'd0: t = '{12'd640, 12'd480, 12'd16, 12'd96, 12'd800,
                  12'd10, 12'd2, 12'd525, 1'b0, 1'b0};
      2'd1: t = '{12'd800, 12'd600, 12'd40, 12'd128, 12'd1056,
                  12'd1, 12'd4, 12'd628, 1'b1, 1'b1};
      2'd2: t = '{12'd1280, 12'd720, 12'd110, 12'd40, 12'd1650,
                  12'd5, 12'd5, 12'd750, 1'b1, 1'b1};
      default: t = '{12'd1280, 12'd1024, 12'd48, 12'd112, 12'd1688,
                     12'd1, 12'd3, 12'd1066, 1'b1, 1'b1};
    endcase
    return t;
  endfunction

  state_t        state, state_n;
  logic [HW-1:0] cnt, cnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [1:0]    tgt, tgt_n;
  logic          from_init, from_init_n;
  logic          same_pend, same_pend_n;
  logic          ack_q, ack_n;
  logic          drop_q, drop_n;
  logic          busy_q;
  logic          load;
  logic          wdt_to;
  mode_t         prm;

`ifdef VGA_MODE_CTRL_WDT_EN
  logic [23:0] wdt;
  logic        waiting;

  assign waiting = (state == WAIT_FRAME) || (state == RUN_BLANK);
  assign wdt_to  = waiting && (wdt == 24'(WDT_CYCLES - 1));

  // Restart the timeout window on every state change and every counted frame.
  always_ff @(posedge pxl_clk or negedge pxl_rstn) begin
    if (!pxl_rstn) begin
      wdt <= '0;
    end else if ((state_n != state) || wdt_to ||
                 ((state == RUN_BLANK) && frame_start)) begin
      wdt <= '0;
    end else if (waiting) begin
      wdt <= wdt + 24'd1;
    end
  end
`else
  assign wdt_to = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    fcnt_n      = fcnt;
    tgt_n       = tgt;
    from_init_n = from_init;
    same_pend_n = 1'b0;
    ack_n       = same_pend;
    drop_n      = drop_q;
    load        = 1'b0;
    unique case (state)
      INIT: begin
        if (cnt == H_LAST) begin
          state_n     = RUN_BLANK;
          cnt_n       = '0;
          fcnt_n      = '0;
          from_init_n = 1'b1;
        end else begin
          cnt_n = cnt + HW'(1);
        end
      end
      IDLE: begin
        if (host.mode_req) begin
          if (host.mode_sel != mode_cur) begin
            tgt_n   = host.mode_sel;
            drop_n  = 1'b0;
            state_n = WAIT_FRAME;
          end else begin
            same_pend_n = 1'b1;
          end
        end
      end
      WAIT_FRAME: begin
        if (frame_start || wdt_to) begin
          state_n = HALT;
          cnt_n   = '0;
          load    = 1'b1;
        end
      end
      HALT: begin
        if (cnt == H_LAST) begin
          state_n     = RUN_BLANK;
          cnt_n       = '0;
          fcnt_n      = '0;
          from_init_n = 1'b0;
        end else begin
          cnt_n = cnt + HW'(1);
        end
      end
      RUN_BLANK: begin
        if (frame_start || wdt_to) begin
          if (fcnt == F_LAST) begin
            state_n = IDLE;
            ack_n   = !from_init;
          end else begin
            fcnt_n = fcnt + FW'(1);
          end
        end
      end
      default: state_n = INIT;
    endcase
    if (host.mode_req && (state != IDLE))
      drop_n = 1'b1;
  end

  always_ff @(posedge pxl_clk or negedge pxl_rstn) begin
    if (!pxl_rstn) begin
      state     <= INIT;
      cnt       <= '0;
      fcnt      <= '0;
      tgt       <= 2'(RESET_MODE);
      from_init <= 1'b0;
      same_pend <= 1'b0;
      ack_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b1;
      tg_en     <= 1'b0;
      blank     <= 1'b1;
      mode_cur  <= 2'(RESET_MODE);
      prm       <= mode_tab(2'(RESET_MODE));
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fcnt      <= fcnt_n;
      tgt       <= tgt_n;
      from_init <= from_init_n;
      same_pend <= same_pend_n;
      ack_q     <= ack_n;
      drop_q    <= drop_n;
      busy_q    <= (state_n != IDLE);
      tg_en     <= (state_n != INIT) && (state_n != HALT);
      blank     <= (state_n != IDLE);
      if (load) begin
        mode_cur <= tgt;
        prm      <= mode_tab(tgt);
      end
    end
  end

  assign host.mode_ack = ack_q;
  assign host.busy     = busy_q;
  assign host.req_drop = drop_q;

  assign frame_width  = prm.w;
  assign frame_height = prm.h;
  assign h_fp         = prm.hfp;
  assign h_pw         = prm.hpw;
  assign h_max        = prm.hmax;
  assign v_fp         = prm.vfp;
  assign v_pw         = prm.vpw;
  assign v_max        = prm.vmax;
  assign h_pol        = prm.hpol;
  assign v_pol        = prm.vpol;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: reset/init, same-mode ack,
// switches, dropped requests, mid-switch reset, optional watchdog.
module tb_vga_mode_ctrl;
  logic        pxl_clk = 1'b0;
  logic        pxl_rstn;
  logic        frame_start;
  logic        tg_en, blank, h_pol, v_pol;
  logic [1:0]  mode_cur;
  logic [11:0] frame_width, frame_height, h_fp, h_pw, h_max;
  logic [11:0] v_fp, v_pw, v_max;

  int vec  = 0;
  int miss = 0;
  int ack_cnt = 0;

  vga_mode_ctrl_if host ();

  vga_mode_ctrl #(
    .RESET_MODE(3), .HALT_CYCLES(16),
    .BLANK_FRAMES(2), .WDT_CYCLES(100)
  ) dut (
    .pxl_clk(pxl_clk), .pxl_rstn(pxl_rstn), .host(host),
    .frame_start(frame_start), .tg_en(tg_en), .blank(blank),
    .mode_cur(mode_cur), .frame_width(frame_width),
    .frame_height(frame_height), .h_fp(h_fp), .h_pw(h_pw),
    .h_max(h_max), .v_fp(v_fp), .v_pw(v_pw), .v_max(v_max),
    .h_pol(h_pol), .v_pol(v_pol)
  );

  always #5 pxl_clk = ~pxl_clk;

  always @(negedge pxl_clk) if (host.mode_ack === 1'b1) ack_cnt++;

  task automatic tick;
    @(posedge pxl_clk);
    #1;
  endtask

  task automatic frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic req(input logic [1:0] m);
    host.mode_sel = m;
    host.mode_req = 1'b1;
    tick();
    host.mode_req = 1'b0;
  endtask

  // Walk the 16 halt edges, counting samples with tg_en low.
  task automatic run_halt(output int low, input int inj_f, input int inj_r);
    low = 0;
    for (int i = 1; i <= 16; i++) begin
      frame_start = (i == inj_f);
      host.mode_req = (i == inj_r);
      if (i == inj_r) host.mode_sel = 2'd1;
      tick();
      frame_start = 1'b0;
      host.mode_req = 1'b0;
      if (tg_en === 1'b0) low++;
    end
  endtask

  task automatic test_reset;
    int low;
    pxl_rstn = 1'b0;
    frame_start = 1'b0;
    host.mode_req = 1'b0;
    host.mode_sel = 2'd0;
    #23;
    vec++;
    if ({tg_en, blank, host.busy, host.mode_ack, host.req_drop} !== 5'b01100) begin
      miss++;
      $display("FAIL rst_flags: got %b want 01100",
        {tg_en, blank, host.busy, host.mode_ack, host.req_drop});
    end
    vec++;
    if (h_max !== 12'd1688 || frame_height !== 12'd1024) begin
      miss++; $display("FAIL rst_params: got %0d/%0d want 1688/1024", h_max, frame_height);
    end
    vec++;
    if (mode_cur !== 2'd3) begin
      miss++; $display("FAIL rst_mode: got %0d want 3", mode_cur);
    end
    @(posedge pxl_clk); #1;
    pxl_rstn = 1'b1;
    run_halt(low, 0, 0);
    vec++;
    if (low != 15 || tg_en !== 1'b1 || blank !== 1'b1) begin
      miss++; $display("FAIL init_halt: got low=%0d tg_en=%b blank=%b want 15/1/1", low, tg_en, blank);
    end
    frame();
    vec++;
    if (blank !== 1'b1) begin
      miss++; $display("FAIL init_frame1: got blank=%b want 1", blank);
    end
    frame();
    vec++;
    if ({blank, host.busy, tg_en} !== 3'b001) begin
      miss++; $display("FAIL init_done: got %b want 001", {blank, host.busy, tg_en});
    end
    tick();
    vec++;
    if (ack_cnt != 0) begin
      miss++; $display("FAIL init_noack: got %0d want 0", ack_cnt);
    end
  endtask

  task automatic test_same_mode;
    int base = ack_cnt;
    req(2'd3);
    vec++;
    if ({host.mode_ack, host.busy, blank} !== 3'b000) begin
      miss++; $display("FAIL same_n: got %b want 000", {host.mode_ack, host.busy, blank});
    end
    tick();
    vec++;
    if ({host.mode_ack, host.busy, blank} !== 3'b100) begin
      miss++; $display("FAIL same_n1: got %b want 100", {host.mode_ack, host.busy, blank});
    end
    tick();
    vec++;
    if (host.mode_ack !== 1'b0 || ack_cnt - base != 1) begin
      miss++; $display("FAIL same_once: got ack=%b cnt=%0d want 0/1", host.mode_ack, ack_cnt - base);
    end
  endtask

  task automatic test_switch;
    int low, base;
    req(2'd0);
    vec++;
    if ({blank, host.busy, tg_en} !== 3'b111 || h_max !== 12'd1688) begin
      miss++; $display("FAIL sw_accept: got %b h_max=%0d want 111/1688", {blank, host.busy, tg_en}, h_max);
    end
    tick(); tick();
    frame();
    vec++;
    if (tg_en !== 1'b0 || h_max !== 12'd800 || v_max !== 12'd525 || h_pol !== 1'b0) begin
      miss++; $display("FAIL sw_halt: got tg_en=%b h=%0d v=%0d pol=%b want 0/800/525/0", tg_en, h_max, v_max, h_pol);
    end
    vec++;
    if (mode_cur !== 2'd0 || frame_width !== 12'd640) begin
      miss++; $display("FAIL sw_mode: got %0d/%0d want 0/640", mode_cur, frame_width);
    end
    run_halt(low, 5, 0);
    vec++;
    if (low != 15 || tg_en !== 1'b1 || blank !== 1'b1) begin
      miss++; $display("FAIL sw_halt_len: got low=%0d tg_en=%b want 15/1", low, tg_en);
    end
    base = ack_cnt;
    frame();
    vec++;
    if (blank !== 1'b1 || host.mode_ack !== 1'b0) begin
      miss++; $display("FAIL sw_frame1: got blank=%b ack=%b want 1/0", blank, host.mode_ack);
    end
    frame();
    vec++;
    if ({host.mode_ack, blank, host.busy} !== 3'b100) begin
      miss++; $display("FAIL sw_done: got %b want 100", {host.mode_ack, blank, host.busy});
    end
    tick();
    vec++;
    if (host.mode_ack !== 1'b0 || ack_cnt - base != 1) begin
      miss++; $display("FAIL sw_ack_once: got ack=%b cnt=%0d want 0/1", host.mode_ack, ack_cnt - base);
    end
  endtask

  task automatic test_req_drop;
    int low;
    req(2'd2);
    frame();
    run_halt(low, 0, 3);
    vec++;
    if (host.req_drop !== 1'b1) begin
      miss++; $display("FAIL drop_set: got %b want 1", host.req_drop);
    end
    frame();
    frame();
    vec++;
    if (mode_cur !== 2'd2 || h_max !== 12'd1650 || v_max !== 12'd750) begin
      miss++; $display("FAIL drop_target: got m=%0d h=%0d v=%0d want 2/1650/750", mode_cur, h_max, v_max);
    end
    vec++;
    if (host.mode_ack !== 1'b1 || host.req_drop !== 1'b1) begin
      miss++; $display("FAIL drop_ack: got ack=%b drop=%b want 1/1", host.mode_ack, host.req_drop);
    end
    tick();
    req(2'd1);
    vec++;
    if (host.req_drop !== 1'b0 || host.busy !== 1'b1) begin
      miss++; $display("FAIL drop_clear: got drop=%b busy=%b want 0/1", host.req_drop, host.busy);
    end
  endtask

  task automatic test_reset_mid;
    int low, base;
    frame();
    vec++;
    if (mode_cur !== 2'd1 || h_max !== 12'd1056 || v_max !== 12'd628) begin
      miss++; $display("FAIL mid_load: got m=%0d h=%0d v=%0d want 1/1056/628", mode_cur, h_max, v_max);
    end
    run_halt(low, 0, 0);
    frame();
    base = ack_cnt;
    pxl_rstn = 1'b0;
    #2;
    vec++;
    if (mode_cur !== 2'd3 || h_max !== 12'd1688 ||
        {tg_en, blank, host.busy, host.mode_ack} !== 4'b0110) begin
      miss++; $display("FAIL mid_rst: got m=%0d h=%0d flags=%b want 3/1688/0110",
        mode_cur, h_max, {tg_en, blank, host.busy, host.mode_ack});
    end
    @(posedge pxl_clk); #1;
    pxl_rstn = 1'b1;
    run_halt(low, 0, 0);
    frame();
    frame();
    tick();
    vec++;
    if (host.busy !== 1'b0 || mode_cur !== 2'd3 || ack_cnt - base != 0) begin
      miss++; $display("FAIL mid_reinit: got busy=%b m=%0d acks=%0d want 0/3/0", host.busy, mode_cur, ack_cnt - base);
    end
  endtask

`ifdef VGA_MODE_CTRL_WDT_EN
  task automatic test_wdt;
    int t_halt = -1;
    int t_ack = -1;
    req(2'd2);
    for (int k = 1; k <= 400 && t_ack < 0; k++) begin
      tick();
      if (t_halt < 0 && tg_en === 1'b0) t_halt = k;
      if (host.mode_ack === 1'b1) t_ack = k;
    end
    vec++;
    if (t_halt != 100) begin
      miss++; $display("FAIL wdt_halt: got %0d want 100", t_halt);
    end
    vec++;
    if (t_ack != 316 || mode_cur !== 2'd2) begin
      miss++; $display("FAIL wdt_ack: got t=%0d m=%0d want 316/2", t_ack, mode_cur);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_same_mode();
    test_switch();
    test_req_drop();
    test_reset_mid();
`ifdef VGA_MODE_CTRL_WDT_EN
    test_wdt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
